// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared event codes and button FSM states for the LED control path
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        EVT_NONE   = 3'd0,
        EVT_SHORT  = 3'd1,
        EVT_MEDIUM = 3'd2,
        EVT_LONG   = 3'd3,
        EVT_DOUBLE = 3'd4
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS1 = 2'd1,
        ST_GAP    = 2'd2,
        ST_PRESS2 = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus stability-count debouncer with edge strobes
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic button,
    output logic level,
    output logic press_edge,
    output logic release_edge
);

    // Counter value on the last differing sample before the level flips
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             press_edge_q, press_edge_d;
    logic             release_edge_q, release_edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_pressed;

    assign sample_pressed = ~sync_q[1];

    // Synchroniser shift and stability counter; level flips on the DEBOUNCE_CYC-th differing sample
    always_comb begin
        sync_d         = {sync_q[0], button};
        level_d        = level_q;
        press_edge_d   = 1'b0;
        release_edge_d = 1'b0;
        cnt_d          = cnt_q;
        if (sample_pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
            cnt_d          = '0;
            level_d        = sample_pressed;
            press_edge_d   = sample_pressed;
            release_edge_d = ~sample_pressed;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; pin reads as released while in reset
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q         <= 2'b11;
            level_q        <= 1'b0;
            press_edge_q   <= 1'b0;
            release_edge_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            sync_q         <= sync_d;
            level_q        <= level_d;
            press_edge_q   <= press_edge_d;
            release_edge_q <= release_edge_d;
            cnt_q          <= cnt_d;
        end
    end

    assign level        = level_q;
    assign press_edge   = press_edge_q;
    assign release_edge = release_edge_q;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies debounced button gestures into SHORT/MEDIUM/LONG/DOUBLE events
module button_event_decoder
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned SHORT_MAX    = 100000000,
    parameter int unsigned LONG_MIN     = 250000000,
    parameter int unsigned DOUBLE_GAP   = 25000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             button,
    output logic             pressed,
    output logic             evt_valid,
    output logic [2:0]       evt_code,
    output logic [CNT_W-1:0] hold_cycles,
    input  logic             evt_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] SHORT_MAX_C  = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] LONG_MIN_C   = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0] DOUBLE_GAP_C = CNT_W'(DOUBLE_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic db_level, db_press, db_release;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] latch_q, latch_d;
    logic             evt_valid_q, evt_valid_d;
    evt_code_t        evt_code_q, evt_code_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             overrun_q, overrun_d;

    logic             emit;
    evt_code_t        emit_code;
    logic [CNT_W-1:0] emit_hold;

    button_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .button       (button),
        .level        (db_level),
        .press_edge   (db_press),
        .release_edge (db_release)
    );

    // Press/gap duration counters; the edge cycle itself counts as the first cycle
    always_comb begin
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        if (db_press) begin
            press_cnt_d = CNT_W'(1);
        end else if (db_level && (press_cnt_q != CNT_MAX)) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
        if (db_release) begin
            gap_cnt_d = CNT_W'(1);
        end else if (!db_level && (gap_cnt_q != CNT_MAX)) begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
    end

    // Gesture FSM next state; a press arriving exactly as the gap expires starts a new gesture
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (db_press) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (db_release) state_d = (press_cnt_q < SHORT_MAX_C) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q >= DOUBLE_GAP_C) state_d = db_press ? ST_PRESS1 : ST_IDLE;
                else if (db_press)             state_d = ST_PRESS2;
            end
            ST_PRESS2: begin
                if (db_release) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gesture FSM outputs: event emission and first-press duration latch
    always_comb begin
        emit      = 1'b0;
        emit_code = EVT_NONE;
        emit_hold = '0;
        latch_d   = latch_q;
        case (state_q)
            ST_PRESS1: begin
                if (db_release) begin
                    if (press_cnt_q < SHORT_MAX_C) begin
                        latch_d = press_cnt_q;
                    end else begin
                        emit      = 1'b1;
                        emit_code = (press_cnt_q < LONG_MIN_C) ? EVT_MEDIUM : EVT_LONG;
                        emit_hold = press_cnt_q;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q >= DOUBLE_GAP_C) begin
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                    emit_hold = latch_q;
                end
            end
            ST_PRESS2: begin
                if (db_release) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    emit_hold = latch_q;
                end
            end
            default: ;
        endcase
    end

    // Single-entry pending event; a new event while the old one is unaccepted is dropped
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        hold_d      = hold_q;
        overrun_d   = overrun_q;
        if (emit) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_code_d  = emit_code;
                hold_d      = emit_hold;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
            evt_code_d  = EVT_NONE;
            hold_d      = '0;
        end
    end

    // State registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= ST_IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            latch_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_NONE;
            hold_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            latch_q     <= latch_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            hold_q      <= hold_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pressed     = db_level;
    assign evt_valid   = evt_valid_q;
    assign evt_code    = evt_code_q;
    assign hold_cycles = hold_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder
module tb_button_event_decoder;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        button = 1'b1;
    logic        evt_ready = 1'b1;
    logic        pressed;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic [31:0] hold_cycles;
    logic        overrun;

    always #5 pclk = ~pclk;

    button_event_decoder #(
        .DEBOUNCE_CYC (4),
        .SHORT_MAX    (100),
        .LONG_MIN     (250),
        .DOUBLE_GAP   (25),
        .CNT_W        (32)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .button      (button),
        .pressed     (pressed),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .hold_cycles (hold_cycles),
        .evt_ready   (evt_ready),
        .overrun     (overrun)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Observed events (accepted handshakes) and timing marks
    logic [2:0]  q_code[$];
    logic [31:0] q_hold[$];
    int          rel_cyc = 0;
    int          rise_cyc = 0;
    bit          pressed_seen = 0;
    bit          stable_err = 0;
    logic        pressed_prev = 0, valid_prev = 0, ready_prev = 1;
    logic [2:0]  code_prev = 0;
    logic [31:0] hold_prev = 0;

    always @(negedge pclk) begin
        if (!pressed && pressed_prev) rel_cyc = cyc;
        if (pressed) pressed_seen = 1;
        if (evt_valid && !valid_prev) rise_cyc = cyc;
        if (evt_valid && valid_prev && !ready_prev &&
            (evt_code != code_prev || hold_cycles != hold_prev)) stable_err = 1;
        if (evt_valid && evt_ready) begin
            q_code.push_back(evt_code);
            q_hold.push_back(hold_cycles);
        end
        pressed_prev = pressed;
        valid_prev   = evt_valid;
        ready_prev   = evt_ready;
        code_prev    = evt_code;
        hold_prev    = hold_cycles;
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic press(input int len, input int gap);
        button = 1'b0;
        cycles(len);
        button = 1'b1;
        cycles(gap);
    endtask

    task automatic clear_q();
        q_code.delete();
        q_hold.delete();
    endtask

    task automatic check_event(input string name, input int idx, input int code, input int hold);
        if (q_code.size() > idx) begin
            check({name, "_code"}, q_code[idx], code);
            check({name, "_hold"}, q_hold[idx], hold);
        end else begin
            check({name, "_present"}, q_code.size(), idx + 1);
        end
    endtask

    typedef struct {
        int press_len;
        int exp_code;
        int exp_hold;
        int exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{60,  1, 60,  26};
        vecs[1] = '{99,  1, 99,  26};
        vecs[2] = '{100, 2, 100, 1};
        vecs[3] = '{249, 2, 249, 1};
        vecs[4] = '{250, 3, 250, 1};
        vecs[5] = '{150, 2, 150, 1};

        // Reset state
        cycles(3);
        check("rst_pressed", pressed, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_hold", hold_cycles, 0);
        check("rst_overrun", overrun, 0);
        preset_n = 1'b1;
        cycles(10);

        // Single presses: classification, duration and event latency
        for (int i = 0; i < 6; i++) begin
            clear_q();
            press(vecs[i].press_len, 40);
            check($sformatf("vec%0d_count", i), q_code.size(), 1);
            check_event($sformatf("vec%0d", i), 0, vecs[i].exp_code, vecs[i].exp_hold);
            check($sformatf("vec%0d_latency", i), rise_cyc - rel_cyc, vecs[i].exp_lat);
        end
        check("no_overrun_ready", overrun, 0);

        // Short press then second press within the gap: single DOUBLE
        clear_q();
        press(50, 24);
        press(300, 60);
        check("double_count", q_code.size(), 1);
        check_event("double", 0, 4, 50);

        // Gap of exactly DOUBLE_GAP: SHORT then LONG
        clear_q();
        press(50, 25);
        press(300, 60);
        check("short_long_count", q_code.size(), 2);
        check_event("sl_first", 0, 1, 50);
        check_event("sl_second", 1, 3, 300);

        // Glitches shorter than the debounce window
        clear_q();
        pressed_seen = 0;
        for (int i = 0; i < 5; i++) press(3, 10);
        cycles(40);
        check("glitch_pressed", pressed_seen, 0);
        check("glitch_events", q_code.size(), 0);

        // Consumer stalled: second event dropped, first held stable
        clear_q();
        evt_ready = 1'b0;
        stable_err = 0;
        press(150, 40);
        press(180, 40);
        check("ovr_valid", evt_valid, 1);
        check("ovr_code", evt_code, 2);
        check("ovr_hold", hold_cycles, 150);
        check("ovr_flag", overrun, 1);
        check("ovr_stable", stable_err, 0);
        evt_ready = 1'b1;
        @(negedge pclk);
        check("ovr_accept_cycle_valid", evt_valid, 1);
        cycles(1);
        check("ovr_drop_valid", evt_valid, 0);
        check("ovr_drop_code", evt_code, 0);
        check_event("ovr_accepted", 0, 2, 150);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of a press
        clear_q();
        button = 1'b0;
        cycles(86);
        check("mid_pressed_before", pressed, 1);
        preset_n = 1'b0;
        #1;
        check("mid_rst_pressed", pressed, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        button = 1'b1;
        cycles(3);
        preset_n = 1'b1;
        cycles(60);
        check("post_rst_events", q_code.size(), 0);
        check("post_rst_valid", evt_valid, 0);
        press(150, 40);
        check("post_rst_count", q_code.size(), 1);
        check_event("post_rst", 0, 2, 150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
